// File: rtl/ram_requester.sv
// ram_requester: drives the start/done side of the 32-over-16-bit RAM controller (ram_control)
// on behalf of the cache. It accepts one 32-bit word load or store per transaction through a
// valid/ready handshake, and converts the byte address into a halfword base. It then pulses
// the matching start and holds base/data stable until done. Finally it returns data and status
// through a valid/ready response. Misaligned requests are rejected without touching the RAM.
// A missing done within TIMEOUT_CYCLES raises a sticky fault. While the fault is set, every
// later request is rejected.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake; req_we, req_addr, req_wdata carry the request
//   resp_valid/resp_ready        response handshake; resp_rdata, resp_err carry the response
//   fault                        sticky timeout flag, cleared only by reset
//   ram_rd_start/ram_wr_start    one-cycle start pulses to ram_control
//   ram_rd_addr_base/ram_wr_addr_base   halfword index of the low half (high half at base+1)
//   ram_wr_data_in               word to store
//   ram_rd_done/ram_wr_done      completion pulses from ram_control
//   ram_rd_data_out              assembled read word, valid while ram_rd_done is high
module ram_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        fault,
  output logic        ram_rd_start,
  output logic        ram_wr_start,
  output logic [31:0] ram_rd_addr_base,
  output logic [31:0] ram_wr_addr_base,
  output logic [31:0] ram_wr_data_in,
  input  logic        ram_rd_done,
  input  logic        ram_wr_done,
  input  logic [31:0] ram_rd_data_out
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q;
  logic            we_q;
  logic [31:0]     base_q;
  logic [31:0]     wdata_q;
  logic [CntW-1:0] cnt_q;

  // ram_control samples these combinationally, so they only change when a request is accepted.
  assign ram_rd_addr_base = base_q;
  assign ram_wr_addr_base = base_q;
  assign ram_wr_data_in   = wdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      base_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      fault        <= 1'b0;
      ram_rd_start <= 1'b0;
      ram_wr_start <= 1'b0;
    end else begin
      // Starts are single-cycle pulses; they are only raised on the accepting edge.
      ram_rd_start <= 1'b0;
      ram_wr_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q      <= req_we;
            base_q    <= {1'b0, req_addr[31:1]};
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (fault || (req_addr[1:0] != 2'b00)) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state_q <= StIssue;
              if (req_we) begin
                ram_wr_start <= 1'b1;
              end else begin
                ram_rd_start <= 1'b1;
              end
            end
          end
        end
        StIssue: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          cnt_q <= cnt_q + CntW'(1);
          // A done of the other direction is not ours and is ignored.
          if (we_q ? ram_wr_done : ram_rd_done) begin
            state_q    <= StResp;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= we_q ? 32'h0 : ram_rd_data_out;
          end else if (cnt_q == CntLast) begin
            state_q    <= StResp;
            fault      <= 1'b1;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end
        end
        StResp: begin
          if (resp_ready) begin
            state_q    <= StIdle;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
